instruction_cycle_controller: RTL and testbench



---
 rtl/instruction_cycle_controller.sv | 128 ++++++++++++
 tb/tb_instruction_cycle_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cycle_controller.sv
// Instruction-cycle control FSM: sequences fetch, decode and execute from the IR opcode field,
// and drives the datapath IR/PC/A load strobes, mux selects and the data-memory write strobe.
module instruction_cycle_controller #(
    parameter bit INPUT_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [2:0] IR75,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    output logic       IRload,
    output logic       PCload,
    output logic       IMPsel,
    output logic       MeminstSel,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       MemWr,
    output logic       Halt,
    output logic [3:0] state
);

    // Execute states sit at {1'b1, opcode} so DECODE can branch without a lookup table.
    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_INREL  = 4'd3,
        S_LOAD   = 4'd8,
        S_STORE  = 4'd9,
        S_ADD    = 4'd10,
        S_SUB    = 4'd11,
        S_INPUT  = 4'd12,
        S_JZ     = 4'd13,
        S_JPOS   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    state_t state_q;
    state_t state_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = state_t'({1'b1, IR75});
            S_INPUT: begin
                if (!Enter) begin
                    state_d = S_INPUT;
                end else if (INPUT_HANDSHAKE) begin
                    state_d = S_INREL;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_INREL:  state_d = Enter ? S_INREL : S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        IRload     = 1'b0;
        PCload     = 1'b0;
        IMPsel     = 1'b0;
        MeminstSel = 1'b0;
        Asel       = 2'b00;
        Aload      = 1'b0;
        Sub        = 1'b0;
        MemWr      = 1'b0;
        Halt       = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            S_DECODE: MeminstSel = 1'b1;
            S_LOAD: begin
                MeminstSel = 1'b1;
                Asel       = 2'b10;
                Aload      = 1'b1;
            end
            S_STORE: begin
                MeminstSel = 1'b1;
                MemWr      = 1'b1;
            end
            S_ADD: begin
                MeminstSel = 1'b1;
                Aload      = 1'b1;
            end
            S_SUB: begin
                MeminstSel = 1'b1;
                Aload      = 1'b1;
                Sub        = 1'b1;
            end
            // A loads only in the cycle Enter is first seen; INREL then swallows the held level.
            S_INPUT: begin
                Asel  = 2'b01;
                Aload = Enter;
            end
            S_JZ: begin
                IMPsel = 1'b1;
                PCload = Aeq0;
            end
            S_JPOS: begin
                IMPsel = 1'b1;
                PCload = Apos;
            end
            S_HALT:  Halt = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_instruction_cycle_controller.sv
// Self-checking bench: instruction-level reference traces (randomized operands, waits and don't-care
// inputs) compared cycle by cycle against two controllers, with and without the Enter handshake.
module tb_instruction_cycle_controller;

    logic       clk;
    logic       clear;
    logic [2:0] IR75;
    logic       Aeq0, Apos, Enter;

    logic       irl1, pcl1, imp1, mis1, al1, sub1, mw1, h1;
    logic [1:0] asel1;
    logic [3:0] st1;
    logic       irl0, pcl0, imp0, mis0, al0, sub0, mw0, h0;
    logic [1:0] asel0;
    logic [3:0] st0;

    instruction_cycle_controller #(.INPUT_HANDSHAKE(1'b1)) dut (
        .clk(clk), .clear(clear), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
        .IRload(irl1), .PCload(pcl1), .IMPsel(imp1), .MeminstSel(mis1), .Asel(asel1),
        .Aload(al1), .Sub(sub1), .MemWr(mw1), .Halt(h1), .state(st1)
    );

    instruction_cycle_controller #(.INPUT_HANDSHAKE(1'b0)) dut_nohs (
        .clk(clk), .clear(clear), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
        .IRload(irl0), .PCload(pcl0), .IMPsel(imp0), .MeminstSel(mis0), .Asel(asel0),
        .Aload(al0), .Sub(sub0), .MemWr(mw0), .Halt(h0), .state(st0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {IRload, PCload, IMPsel, MeminstSel, Asel[1:0], Aload, Sub, MemWr, Halt}
    logic [9:0] outs1, outs0;
    assign outs1 = {irl1, pcl1, imp1, mis1, asel1, al1, sub1, mw1, h1};
    assign outs0 = {irl0, pcl0, imp0, mis0, asel0, al0, sub0, mw0, h0};

    typedef struct {
        logic [2:0] ir;
        logic       aeq0;
        logic       apos;
        logic       enter;
        logic [3:0] st;
        logic [9:0] outs;
    } cyc_t;

    cyc_t trace[$];
    int   compared = 0;
    int   mismatched = 0;

    function automatic logic [9:0] mk(bit irl, bit pcl, bit imp, bit mis, bit [1:0] asel,
                                      bit al, bit sub, bit mw, bit h);
        return {irl, pcl, imp, mis, asel, al, sub, mw, h};
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [2:0] ir, input bit aeq0, input bit apos, input bit enter,
                        input logic [3:0] st, input logic [9:0] outs);
        cyc_t c;
        c.ir = ir; c.aeq0 = aeq0; c.apos = apos; c.enter = enter; c.st = st; c.outs = outs;
        trace.push_back(c);
    endtask

    // Expected cycles of one instruction, written from the instruction semantics.
    task automatic push_instr(input logic [2:0] op, input bit fa, input bit fp,
                              input int wait_cycles, input int hold_cycles, input bit hs);
        push(op, rb(), rb(), rb(), 4'd1, mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        push(op, rb(), rb(), rb(), 4'd2, mk(0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
        case (op)
            3'd0: push(3'($urandom), rb(), rb(), rb(), 4'd8,  mk(0, 0, 0, 1, 2'b10, 1, 0, 0, 0));
            3'd1: push(3'($urandom), rb(), rb(), rb(), 4'd9,  mk(0, 0, 0, 1, 2'b00, 0, 0, 1, 0));
            3'd2: push(3'($urandom), rb(), rb(), rb(), 4'd10, mk(0, 0, 0, 1, 2'b00, 1, 0, 0, 0));
            3'd3: push(3'($urandom), rb(), rb(), rb(), 4'd11, mk(0, 0, 0, 1, 2'b00, 1, 1, 0, 0));
            3'd4: begin
                for (int i = 0; i < wait_cycles; i++)
                    push(3'($urandom), rb(), rb(), 1'b0, 4'd12, mk(0, 0, 0, 0, 2'b01, 0, 0, 0, 0));
                push(3'($urandom), rb(), rb(), 1'b1, 4'd12, mk(0, 0, 0, 0, 2'b01, 1, 0, 0, 0));
                if (hs) begin
                    for (int i = 1; i < hold_cycles; i++)
                        push(3'($urandom), rb(), rb(), 1'b1, 4'd3, 10'd0);
                    push(3'($urandom), rb(), rb(), 1'b0, 4'd3, 10'd0);
                end
            end
            3'd5: push(3'($urandom), fa, fp, rb(), 4'd13, mk(0, fa, 1, 0, 2'b00, 0, 0, 0, 0));
            3'd6: push(3'($urandom), fa, fp, rb(), 4'd14, mk(0, fp, 1, 0, 2'b00, 0, 0, 0, 0));
            default: begin
                for (int i = 0; i < 12; i++)
                    push(3'($urandom), rb(), rb(), rb(), 4'd15, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
            end
        endcase
    endtask

    // Replays the queued trace; called at posedge+1, drives each cycle and samples at negedge.
    task automatic play(input string name, input bit use_hs);
        int n = 0;
        while (trace.size() > 0) begin
            cyc_t c = trace.pop_front();
            IR75 = c.ir; Aeq0 = c.aeq0; Apos = c.apos; Enter = c.enter;
            @(negedge clk);
            compared++;
            if (use_hs ? ({st1, outs1} !== {c.st, c.outs}) : ({st0, outs0} !== {c.st, c.outs})) begin
                mismatched++;
                $display("FAIL %s[%0d]: got state=%0d outs=%b, want state=%0d outs=%b", name, n,
                         use_hs ? st1 : st0, use_hs ? outs1 : outs0, c.st, c.outs);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        clear = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        trace.delete();
        push(3'($urandom), rb(), rb(), rb(), 4'd0, 10'd0);
    endtask

    task automatic test_reset();
        clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            IR75 = 3'($urandom); Enter = rb(); Aeq0 = rb(); Apos = rb();
            @(negedge clk);
            compared++;
            if ({st1, outs1} !== 14'd0) begin
                mismatched++;
                $display("FAIL reset_low[%0d]: got state=%0d outs=%b, want 0", i, st1, outs1);
            end
            @(posedge clk); #1;
        end
        clear = 1'b1;
        @(negedge clk);
        compared++;
        if ({st1, outs1} !== 14'd0) begin
            mismatched++;
            $display("FAIL reset_release: got state=%0d outs=%b, want 0", st1, outs1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if ({st1, outs1} !== {4'd1, mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0)}) begin
            mismatched++;
            $display("FAIL reset_fetch: got state=%0d outs=%b, want state=1 outs=%b",
                     st1, outs1, mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_opcode_sweep();
        do_reset();
        for (int op = 0; op < 4; op++) push_instr(3'(op), 1'b0, 1'b0, 0, 1, 1'b1);
        play("opcode_sweep", 1'b1);
    endtask

    task automatic test_input_handshake();
        do_reset();
        push_instr(3'd4, 1'b0, 1'b0, 5, 3, 1'b1);
        push_instr(3'd2, 1'b0, 1'b0, 0, 1, 1'b1);
        play("input_hs", 1'b1);
    endtask

    task automatic test_input_no_handshake();
        do_reset();
        push_instr(3'd4, 1'b0, 1'b0, 5, 1, 1'b0);
        push_instr(3'd4, 1'b0, 1'b0, 0, 1, 1'b0);
        push_instr(3'd1, 1'b0, 1'b0, 0, 1, 1'b0);
        play("input_nohs", 1'b0);
    endtask

    task automatic test_jumps();
        do_reset();
        push_instr(3'd5, 1'b1, 1'b0, 0, 1, 1'b1);
        push_instr(3'd5, 1'b0, 1'b1, 0, 1, 1'b1);
        push_instr(3'd6, 1'b0, 1'b1, 0, 1, 1'b1);
        push_instr(3'd6, 1'b1, 1'b0, 0, 1, 1'b1);
        push_instr(3'd5, 1'b1, 1'b1, 0, 1, 1'b1);
        push_instr(3'd6, 1'b1, 1'b1, 0, 1, 1'b1);
        play("jumps", 1'b1);
    endtask

    task automatic test_halt();
        do_reset();
        push_instr(3'd7, 1'b0, 1'b0, 0, 1, 1'b1);
        play("halt", 1'b1);
        #2 clear = 1'b0;
        #1;
        compared++;
        if ({st1, outs1} !== 14'd0) begin
            mismatched++;
            $display("FAIL halt_async_clear: got state=%0d outs=%b, want 0", st1, outs1);
        end
        @(posedge clk); #1;
        clear = 1'b1;
    endtask

    task automatic test_reset_mid_input();
        do_reset();
        push_instr(3'd4, 1'b0, 1'b0, 2, 1, 1'b1);
        void'(trace.pop_back());   // drop the Enter-high and release cycles; they are driven below
        void'(trace.pop_back());
        play("mid_input_pre", 1'b1);
        Enter = 1'b1;
        #2;
        compared++;
        if ({st1, al1} !== {4'd12, 1'b1}) begin
            mismatched++;
            $display("FAIL mid_input_load: got state=%0d Aload=%b, want state=12 Aload=1", st1, al1);
        end
        clear = 1'b0;
        #1;
        compared++;
        if ({st1, outs1} !== 14'd0) begin
            mismatched++;
            $display("FAIL mid_input_clear: got state=%0d outs=%b, want 0", st1, outs1);
        end
        @(posedge clk); #1;
        clear = 1'b1;
        trace.delete();
        push(3'($urandom), rb(), rb(), rb(), 4'd0, 10'd0);
        push_instr(3'd0, 1'b0, 1'b0, 0, 1, 1'b1);
        play("mid_input_restart", 1'b1);
    endtask

    task automatic test_random_program();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            push_instr(3'($urandom_range(0, 6)), rb(), rb(), $urandom_range(0, 4),
                       $urandom_range(1, 4), 1'b1);
        end
        play("random_prog", 1'b1);
    endtask

    initial begin
        clear = 1'b0; IR75 = 3'd0; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_opcode_sweep();
        test_input_handshake();
        test_input_no_handshake();
        test_jumps();
        test_halt();
        test_reset_mid_input();
        test_random_program();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
